// File: rtl/fp12_result_reader_pkg.sv
// Shared constants for the Fp12 result readback stage: FSM state codes and
// the core input-mode codes that select between executing and reading results.
package fp12_result_reader_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_CORE = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_LAT       = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Core I_INPUTMODE codes, single-bit on this interface.
  localparam logic MODE_EXEC_CORE  = 1'b0;
  localparam logic MODE_REF_RESULT = 1'b1;

  // Width of the pair index, never zero even for a single pair.
  function automatic int pair_width(input int num_pairs);
    return (num_pairs > 1) ? $clog2(num_pairs) : 1;
  endfunction

endpackage

// File: rtl/fp12_result_reader_if.sv
// Valid/ready word stream from the readback stage to the host interface.
interface fp12_result_reader_if #(
  parameter int WORD_W = 384
);
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fp12_result_reader_pair_buffer.sv
// rr_pair_buffer: two-word capture buffer for one RAM access, emptied one
// word per valid/ready handshake; valid depends only on registered state.
module rr_pair_buffer #(
  parameter int WORD_W = 384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] d0,
  input  logic [WORD_W-1:0] d1,
  input  logic              last_pair,
  output logic              valid,
  input  logic              ready,
  output logic [WORD_W-1:0] data,
  output logic              last,
  output logic              pair_done
);

  logic [WORD_W-1:0] word0_q;
  logic [WORD_W-1:0] word1_q;
  logic              sel_q;
  logic              valid_q;
  logic              last_pair_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      sel_q       <= 1'b0;
      last_pair_q <= 1'b0;
    end else if (load) begin
      valid_q     <= 1'b1;
      sel_q       <= 1'b0;
      last_pair_q <= last_pair;
    end else if (valid_q && ready) begin
      if (sel_q) begin
        valid_q <= 1'b0;
        sel_q   <= 1'b0;
      end else begin
        sel_q <= 1'b1;
      end
    end
  end

  // NOTE: wide data storage is not reset; the output is gated by valid_q instead.
  always_ff @(posedge clk) begin
    if (load) begin
      word0_q <= d0;
      word1_q <= d1;
    end
  end

  assign valid     = valid_q;
  assign data      = valid_q ? (sel_q ? word1_q : word0_q) : '0;
  assign last      = valid_q && sel_q && last_pair_q;
  assign pair_done = valid_q && ready && sel_q;

endmodule

// File: rtl/fp12_result_reader.sv
// Fp12 result readback: waits for the pairing core to idle, reads the result
// two words per RAM access and streams it out. Optional: READBACK_CKSUM_EN.
module fp12_result_reader
  import fp12_result_reader_pkg::*;
#(
  parameter int WORD_W    = 384,
  parameter int ADDR_W    = 9,
  parameter int NUM_WORDS = 12,
  parameter int READ_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   core_busy,
  output logic                   ref_mode,
  output logic [ADDR_W-1:0]      raddr1,
  output logic [ADDR_W-1:0]      raddr2,
  input  logic [WORD_W-1:0]      rdata1,
  input  logic [WORD_W-1:0]      rdata2,
  fp12_result_reader_if.master   m,
`ifdef READBACK_CKSUM_EN
  output logic [WORD_W-1:0]      cksum,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_PAIRS = NUM_WORDS / 2;
  localparam int PAIR_W    = pair_width(NUM_PAIRS);
  localparam int LAT_W     = 2;

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT - 1);

  if (NUM_WORDS < 2 || (NUM_WORDS % 2) != 0) begin : g_bad_num_words
    $error("fp12_result_reader: NUM_WORDS must be even and >= 2");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("fp12_result_reader: READ_LAT must be in 1..4");
  end

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_CORE = ST_WAIT_CORE,
    ISSUE     = ST_ISSUE,
    LAT       = ST_LAT,
    DRAIN     = ST_DRAIN,
    DONE      = ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] raddr1_q, raddr2_q;
  logic [ADDR_W-1:0] pair_addr;
  logic              start_ok;
  logic              capture;
  logic              pair_done;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    lat_d    = lat_q;
    start_ok = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          pair_d   = '0;
          state_d  = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (!core_busy) state_d = ISSUE;
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = LAT;
      end
      LAT: begin
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DRAIN: begin
        if (pair_done) begin
          if (pair_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            pair_d  = pair_q + PAIR_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address of the pair about to be issued; the sum wraps modulo 2^ADDR_W.
  assign pair_addr = base_q + (ADDR_W'(pair_d) << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      pair_q   <= '0;
      lat_q    <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      lat_q   <= lat_d;
      if (start_ok) base_q <= base_addr;
      if (state_d == ISSUE) begin
        raddr1_q <= pair_addr;
        raddr2_q <= pair_addr + ADDR_W'(1);
      end
    end
  end

  assign raddr1   = raddr1_q;
  assign raddr2   = raddr2_q;
  assign ref_mode = (state_q inside {ISSUE, LAT, DRAIN, DONE}) ? MODE_REF_RESULT
                                                              : MODE_EXEC_CORE;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  rr_pair_buffer #(
    .WORD_W (WORD_W)
  ) u_pair_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .d0        (rdata1),
    .d1        (rdata2),
    .last_pair (pair_q == LAST_PAIR),
    .valid     (m.valid),
    .ready     (m.ready),
    .data      (m.data),
    .last      (m.last),
    .pair_done (pair_done)
  );

`ifdef READBACK_CKSUM_EN
  logic [WORD_W-1:0] cksum_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      cksum_q <= '0;
    end else if (m.valid && m.ready) begin
      cksum_q <= cksum_q ^ m.data;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_fp12_result_reader.sv
// Self-checking bench for fp12_result_reader: RAM model with read latency,
// randomized data/backpressure, expected words derived from RAM contents.
module tb_fp12_result_reader;

  localparam int WORD_W    = 384;
  localparam int ADDR_W    = 9;
  localparam int NUM_WORDS = 12;
  localparam int READ_LAT  = 1;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              core_busy;
  logic              ref_mode;
  logic [ADDR_W-1:0] raddr1, raddr2;
  logic [WORD_W-1:0] rdata1, rdata2;
  logic              busy, done;
`ifdef READBACK_CKSUM_EN
  logic [WORD_W-1:0] cksum;
`endif

  fp12_result_reader_if #(.WORD_W(WORD_W)) m_if ();

  fp12_result_reader #(
    .WORD_W    (WORD_W),
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_WORDS),
    .READ_LAT  (READ_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .core_busy (core_busy),
    .ref_mode  (ref_mode),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .m         (m_if),
`ifdef READBACK_CKSUM_EN
    .cksum     (cksum),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // RAM model: data appears READ_LAT cycles after the address.
  logic [WORD_W-1:0] mem [RAM_DEPTH];
  logic [WORD_W-1:0] pipe1 [READ_LAT];
  logic [WORD_W-1:0] pipe2 [READ_LAT];

  always @(posedge clk) begin
    pipe1[0] <= mem[raddr1];
    pipe2[0] <= mem[raddr2];
    for (int i = 1; i < READ_LAT; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
  end
  assign rdata1 = pipe1[READ_LAT-1];
  assign rdata2 = pipe2[READ_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                       input logic [WORD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int j = 0; j < WORD_W / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic fill_rand(input logic [ADDR_W-1:0] base);
    for (int i = 0; i < NUM_WORDS; i++) mem[ADDR_W'(base + ADDR_W'(i))] = rand_word();
  endtask

  task automatic fill_count(input logic [ADDR_W-1:0] base);
    for (int i = 0; i < NUM_WORDS; i++)
      mem[ADDR_W'(base + ADDR_W'(i))] = WORD_W'(i + 1);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Consumes the stream and checks it against mem[base+i]; abort_at>0 stops
  // after that many handshakes. start_at_done pulses start during done.
  task automatic run_read(input logic [ADDR_W-1:0] base, input int pct,
                          input int abort_at, input bit start_at_done);
    int                beats = 0;
    int                cycles = 0;
    bit                stalled = 0;
    logic [WORD_W-1:0] hold_d;
    logic              hold_l;
    logic [WORD_W-1:0] exp_w;
    logic [WORD_W-1:0] ck = '0;
    logic [ADDR_W-1:0] a;
    while (beats < NUM_WORDS && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      m_if.ready = ($urandom_range(0, 99) < pct);
      if (stalled) begin
        check("stall_valid", WORD_W'(m_if.valid), WORD_W'(1'b1));
        check("stall_data", m_if.data, hold_d);
        check("stall_last", WORD_W'(m_if.last), WORD_W'(hold_l));
      end
      stalled = m_if.valid && !m_if.ready;
      hold_d  = m_if.data;
      hold_l  = m_if.last;
      if (m_if.valid && m_if.ready) begin
        a     = ADDR_W'(base + ADDR_W'(beats));
        exp_w = mem[a];
        check("data", m_if.data, exp_w);
        check("last", WORD_W'(m_if.last), WORD_W'(beats == NUM_WORDS - 1));
        if (beats % 2 == 0) begin
          check("raddr1", WORD_W'(raddr1), WORD_W'(a));
          check("raddr2", WORD_W'(raddr2), WORD_W'(ADDR_W'(a + ADDR_W'(1))));
          check("ref_mode_drain", WORD_W'(ref_mode), WORD_W'(1'b1));
        end
        ck ^= exp_w;
        beats++;
        if (abort_at > 0 && beats == abort_at) return;
      end
    end
    if (beats < NUM_WORDS) begin
      check("timeout_beats", WORD_W'(beats), WORD_W'(NUM_WORDS));
    end else begin
      @(negedge clk);
      m_if.ready = 1'b0;
      check("done_pulse", WORD_W'(done), WORD_W'(1'b1));
      check("valid_after", WORD_W'(m_if.valid), WORD_W'(1'b0));
`ifdef READBACK_CKSUM_EN
      check("cksum", cksum, ck);
`endif
      if (start_at_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", WORD_W'(done), WORD_W'(1'b0));
      check("idle_after", WORD_W'(busy), WORD_W'(1'b0));
      if (start_at_done) begin
        repeat (3) @(negedge clk);
        check("start_at_done_ignored", WORD_W'(busy), WORD_W'(1'b0));
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] r1, r2, b;
    bit                ok;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    core_busy  = 1'b0;
    m_if.ready = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = rand_word();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", WORD_W'(m_if.valid), '0);
    check("rst_data", m_if.data, '0);
    check("rst_last", WORD_W'(m_if.last), '0);
    check("rst_busy", WORD_W'(busy), '0);
    check("rst_done", WORD_W'(done), '0);
    check("rst_ref_mode", WORD_W'(ref_mode), '0);
    check("rst_raddr1", WORD_W'(raddr1), '0);
    check("rst_raddr2", WORD_W'(raddr2), '0);
    rst = 1'b0;

    // Basic read of 1..12 at 0x040 with ready held high
    fill_count(9'h040);
    do_start(9'h040);
    check("busy_after_start", WORD_W'(busy), WORD_W'(1'b1));
    run_read(9'h040, 100, 0, 1'b0);

    // Core busy: no mode switch or address change while waiting
    core_busy = 1'b1;
    do_start(9'h040);
    r1 = raddr1;
    r2 = raddr2;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ref_mode !== 1'b0 || raddr1 !== r1 || raddr2 !== r2 || m_if.valid !== 1'b0)
        ok = 1'b0;
    end
    check("busy_wait_hold", WORD_W'(ok), WORD_W'(1'b1));
    check("busy_wait_busy", WORD_W'(busy), WORD_W'(1'b1));
    core_busy = 1'b0;
    run_read(9'h040, 100, 0, 1'b0);

    // Backpressure with ~30% ready and random data
    fill_rand(9'h0C3);
    do_start(9'h0C3);
    run_read(9'h0C3, 30, 0, 1'b0);

    // Address wrap-around
    fill_rand(9'h1FA);
    do_start(9'h1FA);
    run_read(9'h1FA, 100, 0, 1'b1);

    // Reset mid-drain after beat 5, then a fresh full read
    fill_count(9'h040);
    do_start(9'h040);
    run_read(9'h040, 100, 5, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_if.ready = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", WORD_W'(m_if.valid), '0);
    check("midrst_busy", WORD_W'(busy), '0);
    check("midrst_done", WORD_W'(done), '0);
    check("midrst_ref_mode", WORD_W'(ref_mode), '0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || m_if.valid !== 1'b0) ok = 1'b0;
    end
    check("midrst_quiet", WORD_W'(ok), WORD_W'(1'b1));
    do_start(9'h040);
    run_read(9'h040, 100, 0, 1'b0);

    // Randomized runs: base, core-busy duration and backpressure
    for (int r = 0; r < 4; r++) begin
      b = ADDR_W'($urandom_range(0, RAM_DEPTH - 1));
      fill_rand(b);
      core_busy = 1'b1;
      do_start(b);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      core_busy = 1'b0;
      run_read(b, $urandom_range(20, 100), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
